// File: rtl/iob_cache_fe_arbiter.sv
// iob_cache_fe_arbiter: round-robin arbiter sharing one iob_cache_axi
// front-end port among N_PORTS IOb-native masters.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   m_avalid_i          per-port request valid
//   m_addr_i            per-port word address (port k at k*ADDR_W)
//   m_wdata_i           per-port write data (port k at k*DATA_W)
//   m_wstrb_i           per-port strobe, all-zero means read
//   m_ready_o           per-port accept
//   m_rdata_o           read data, broadcast to every port
//   m_rvalid_o          per-port read-data valid
//   c_avalid_o, c_addr_o, c_wdata_o, c_wstrb_o   request to cache
//   c_rdata_i, c_rvalid_i, c_ready_i             response from cache
//   err_o               sticky flag: cache rvalid with no read pending
//
// Build option: define IOB_CACHE_FE_ARB_BURST_LOCK_EN to let the
// current winner keep priority for up to BURST_MAX back-to-back
// accepts. Without it, priority rotates after every accept.

module iob_cache_fe_arbiter #(
    parameter int N_PORTS         = 4,
    parameter int ADDR_W          = 30,
    parameter int DATA_W          = 32,
    parameter int RD_FIFO_DEPTH_W = 2,
    parameter int BURST_MAX       = 4,
    parameter int ID_W            = $clog2(N_PORTS)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_PORTS-1:0]            m_avalid_i,
    input  logic [N_PORTS*ADDR_W-1:0]     m_addr_i,
    input  logic [N_PORTS*DATA_W-1:0]     m_wdata_i,
    input  logic [N_PORTS*DATA_W/8-1:0]   m_wstrb_i,
    output logic [N_PORTS-1:0]            m_ready_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic [N_PORTS-1:0]            m_rvalid_o,
    output logic                          c_avalid_o,
    output logic [ADDR_W-1:0]             c_addr_o,
    output logic [DATA_W-1:0]             c_wdata_o,
    output logic [DATA_W/8-1:0]           c_wstrb_o,
    input  logic [DATA_W-1:0]             c_rdata_i,
    input  logic                          c_rvalid_i,
    input  logic                          c_ready_i,
    output logic                          err_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 1 << RD_FIFO_DEPTH_W;
    localparam int PTR_W  = RD_FIFO_DEPTH_W + 1;

    if ((N_PORTS < 2) || (N_PORTS > 16) ||
        (RD_FIFO_DEPTH_W < 1) || (BURST_MAX < 1)) begin : g_bad_cfg
        $error("iob_cache_fe_arbiter: illegal parameter set");
    end

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_nxt;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    win_nxt;
    logic               win_found;
    logic [N_PORTS-1:0] is_wr;
    logic [N_PORTS-1:0] elig;
    logic               accept;
    logic               push;
    logic               pop;
    int unsigned        idx;

    // Outstanding-read ID FIFO. Pointers carry one wrap bit so that
    // full and empty are distinguishable without a counter.
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ID_W-1:0]    id_mem [DEPTH];
    logic [ID_W-1:0]    head_id;
    logic               fifo_full;
    logic               fifo_empty;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr == {~rd_ptr[PTR_W-1], rd_ptr[PTR_W-2:0]});
    assign head_id    = id_mem[rd_ptr[PTR_W-2:0]];

    // A read is held back while the FIFO is full, even if the same
    // cycle frees a slot; this keeps eligibility off the rvalid path.
    always_comb begin
        for (int k = 0; k < N_PORTS; k++) begin
            is_wr[k] = |m_wstrb_i[k*STRB_W +: STRB_W];
            elig[k]  = m_avalid_i[k] & (is_wr[k] | ~fifo_full);
        end
    end

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_PORTS) idx -= N_PORTS;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_nxt = (win_id == ID_W'(N_PORTS - 1)) ? '0 : win_id + 1'b1;

    assign accept = win_found & c_ready_i & ~rst_i;
    assign push   = accept & ~is_wr[win_id];
    assign pop    = c_rvalid_i & ~fifo_empty & ~rst_i;

    assign c_avalid_o = win_found & ~rst_i;
    assign c_addr_o   = m_addr_i[int'(win_id)*ADDR_W +: ADDR_W];
    assign c_wdata_o  = m_wdata_i[int'(win_id)*DATA_W +: DATA_W];
    assign c_wstrb_o  = m_wstrb_i[int'(win_id)*STRB_W +: STRB_W];
    assign m_rdata_o  = c_rdata_i;

    always_comb begin
        m_ready_o = '0;
        if (accept) m_ready_o[win_id] = 1'b1;
    end

    always_comb begin
        m_rvalid_o = '0;
        if (pop) m_rvalid_o[head_id] = 1'b1;
    end

`ifdef IOB_CACHE_FE_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    // While burst_cnt is non-zero, rr_ptr points at the lock owner.
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        if ((burst_cnt != '0) && (win_id == rr_ptr))
            cnt_inc = burst_cnt + 1'b1;
        else
            cnt_inc = CNT_W'(1);
        rr_nxt  = rr_ptr;
        cnt_nxt = burst_cnt;
        if (accept) begin
            if (cnt_inc == CNT_W'(BURST_MAX)) begin
                rr_nxt  = win_nxt;
                cnt_nxt = '0;
            end else begin
                rr_nxt  = win_id;
                cnt_nxt = cnt_inc;
            end
        end else if ((burst_cnt != '0) && !elig[rr_ptr]) begin
            // Owner went away without an accept: hand priority on.
            rr_nxt  = (rr_ptr == ID_W'(N_PORTS - 1)) ? '0 : rr_ptr + 1'b1;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) burst_cnt <= '0;
        else       burst_cnt <= cnt_nxt;
    end
`else
    assign rr_nxt = accept ? win_nxt : rr_ptr;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            err_o  <= 1'b0;
        end else begin
            rr_ptr <= rr_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (c_rvalid_i && fifo_empty) err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr[PTR_W-2:0]] <= win_id;
    end

endmodule
